// File: rtl/rob_commit.sv
// rob_commit
// Eight-entry reorder buffer. Issue allocates an entry at the tail and
// receives its index as a tag. The execution unit writes results back by
// tag in any order. Completed entries are retired from the head in program
// order, one registered commit per cycle.
//
// Ports:
//   clk1          clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of every entry
//   alloc_valid   issue requests a new entry
//   alloc_rd      destination register of the allocating instruction
//   alloc_ready   combinational, high while the buffer is not full
//   alloc_tag     combinational, tag handed to the allocating instruction
//   wb_valid      execution result valid
//   wb_tag        entry index of the result
//   wb_data       result value
//   commit_valid  registered, one-cycle pulse per retired entry
//   commit_tag    registered, tag of the retired entry
//   commit_rd     registered, destination register of the retired entry
//   commit_data   registered, value for the register bank
//   count         registered, number of occupied entries (0..8)
//   empty         combinational, high when count is zero
module rob_commit #(
   parameter int DEPTH = 8,
   parameter int DW    = 8,
   parameter int RW    = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          alloc_valid,
   input  logic [RW-1:0] alloc_rd,
   output logic          alloc_ready,
   output logic [2:0]    alloc_tag,
   input  logic          wb_valid,
   input  logic [2:0]    wb_tag,
   input  logic [DW-1:0] wb_data,
   output logic          commit_valid,
   output logic [2:0]    commit_tag,
   output logic [RW-1:0] commit_rd,
   output logic [DW-1:0] commit_data,
   output logic [3:0]    count,
   output logic          empty
);

   localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] r_done;
   logic [RW-1:0]    r_rd   [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [2:0]       r_head;
   logic [2:0]       r_tail;
   logic [3:0]       r_count;
   logic             r_commit_valid;
   logic [2:0]       r_commit_tag;
   logic [RW-1:0]    r_commit_rd;
   logic [DW-1:0]    r_commit_data;

   logic w_alloc;
   logic w_wb;
   logic w_commit;

   // Head and tail coincide both when empty and when full, so fullness is
   // judged from the count alone. A full buffer refuses allocation even in
   // a cycle that retires, because readiness comes from the registered count.
   // Writeback and commit both look at registered busy/done bits, which is
   // why a writeback to the tail being allocated is dropped and why a
   // writeback to the head only commits one edge later.
   always_comb begin
      alloc_ready = (r_count < FULL_COUNT);
      alloc_tag   = r_tail;
      empty       = (r_count == 4'd0);
      w_alloc     = alloc_valid && alloc_ready;
      w_wb        = wb_valid && r_busy[wb_tag];
      w_commit    = r_busy[r_head] && r_done[r_head];
   end

   // Per-entry storage. The commit clear is written last so that an entry
   // retiring in the same cycle as a late writeback still ends up empty;
   // the retired values were already captured from the old contents.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_done <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
      end else if (flush) begin
         r_busy <= '0;
         r_done <= '0;
      end else begin
         if (w_alloc) begin
            r_busy[r_tail] <= 1'b1;
            r_done[r_tail] <= 1'b0;
            r_rd[r_tail]   <= alloc_rd;
         end
         if (w_wb) begin
            r_done[wb_tag] <= 1'b1;
            r_data[wb_tag] <= wb_data;
         end
         if (w_commit) begin
            r_busy[r_head] <= 1'b0;
            r_done[r_head] <= 1'b0;
         end
      end
   end

   // Pointers and occupancy. The 3-bit pointers wrap naturally from 7 to 0,
   // and an allocate paired with a commit leaves the count where it was.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_alloc) begin
            r_tail <= r_tail + 3'd1;
         end
         if (w_commit) begin
            r_head <= r_head + 3'd1;
         end
         case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered commit port. Flush only kills the valid pulse; the payload
   // keeps whatever was last retired so the register bank sees stable data.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_commit_valid <= 1'b0;
         r_commit_tag   <= '0;
         r_commit_rd    <= '0;
         r_commit_data  <= '0;
      end else if (flush) begin
         r_commit_valid <= 1'b0;
      end else begin
         r_commit_valid <= w_commit;
         if (w_commit) begin
            r_commit_tag  <= r_head;
            r_commit_rd   <= r_rd[r_head];
            r_commit_data <= r_data[r_head];
         end
      end
   end

   assign commit_valid = r_commit_valid;
   assign commit_tag   = r_commit_tag;
   assign commit_rd    = r_commit_rd;
   assign commit_data  = r_commit_data;
   assign count        = r_count;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit
// Directed bench for rob_commit. Inputs change on the falling edge and
// outputs are sampled on the falling edge after each rising edge.
module tb_rob_commit;

   logic       clk1;
   logic       rst_n;
   logic       flush;
   logic       allocValid;
   logic [3:0] allocRd;
   logic       allocReady;
   logic [2:0] allocTag;
   logic       wbValid;
   logic [2:0] wbTag;
   logic [7:0] wbData;
   logic       commitValid;
   logic [2:0] commitTag;
   logic [3:0] commitRd;
   logic [7:0] commitData;
   logic [3:0] count;
   logic       empty;

   int nVectors;
   int nMiscompares;

   rob_commit #(.DEPTH(8), .DW(8), .RW(4)) dut (
      .clk1        (clk1),
      .rst_n       (rst_n),
      .flush       (flush),
      .alloc_valid (allocValid),
      .alloc_rd    (allocRd),
      .alloc_ready (allocReady),
      .alloc_tag   (allocTag),
      .wb_valid    (wbValid),
      .wb_tag      (wbTag),
      .wb_data     (wbData),
      .commit_valid(commitValid),
      .commit_tag  (commitTag),
      .commit_rd   (commitRd),
      .commit_data (commitData),
      .count       (count),
      .empty       (empty)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One rising edge, then back to the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk1);
      @(negedge clk1);
   endtask

   task automatic idleInputs();
      flush      = 1'b0;
      allocValid = 1'b0;
      allocRd    = 4'd0;
      wbValid    = 1'b0;
      wbTag      = 3'd0;
      wbData     = 8'd0;
   endtask

   // Power-on reset state.
   task automatic test_reset();
      rst_n = 1'b0;
      idleInputs();
      step();
      nVectors++;
      if (commitValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_commit_valid: got %b expected 0", commitValid); end
      nVectors++;
      if (count !== 4'd0) begin nMiscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      nVectors++;
      if (allocTag !== 3'd0) begin nMiscompares++; $display("[TB] FAIL reset_alloc_tag: got %0d expected 0", allocTag); end
      nVectors++;
      if (allocReady !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_alloc_ready: got %b expected 1", allocReady); end
      nVectors++;
      if (empty !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
      rst_n = 1'b1;
      step();
   endtask

   // Three allocations completed out of order retire in program order.
   task automatic test_in_order();
      for (int i = 0; i < 3; i++) begin
         allocValid = 1'b1;
         allocRd    = 4'(i + 1);
         step();
         nVectors++;
         if (allocTag !== 3'(i + 1)) begin nMiscompares++; $display("[TB] FAIL inorder_alloc_tag%0d: got %0d expected %0d", i, allocTag, i + 1); end
      end
      allocValid = 1'b0;
      nVectors++;
      if (count !== 4'd3) begin nMiscompares++; $display("[TB] FAIL inorder_count3: got %0d expected 3", count); end
      wbValid = 1'b1; wbTag = 3'd2; wbData = 8'h33;
      step();
      wbTag = 3'd0; wbData = 8'h11;
      step();
      nVectors++;
      if (commitValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL inorder_no_early_commit: got %b expected 0", commitValid); end
      wbTag = 3'd1; wbData = 8'h22;
      step();
      wbValid = 1'b0;
      nVectors++;
      if ({commitValid, commitTag, commitRd, commitData} !== {1'b1, 3'd0, 4'd1, 8'h11}) begin
         nMiscompares++; $display("[TB] FAIL inorder_commit0: got v=%b tag=%0d rd=%0d data=%h expected v=1 tag=0 rd=1 data=11", commitValid, commitTag, commitRd, commitData);
      end
      step();
      nVectors++;
      if ({commitValid, commitTag, commitRd, commitData} !== {1'b1, 3'd1, 4'd2, 8'h22}) begin
         nMiscompares++; $display("[TB] FAIL inorder_commit1: got v=%b tag=%0d rd=%0d data=%h expected v=1 tag=1 rd=2 data=22", commitValid, commitTag, commitRd, commitData);
      end
      step();
      nVectors++;
      if ({commitValid, commitTag, commitRd, commitData} !== {1'b1, 3'd2, 4'd3, 8'h33}) begin
         nMiscompares++; $display("[TB] FAIL inorder_commit2: got v=%b tag=%0d rd=%0d data=%h expected v=1 tag=2 rd=3 data=33", commitValid, commitTag, commitRd, commitData);
      end
      nVectors++;
      if (count !== 4'd0) begin nMiscompares++; $display("[TB] FAIL inorder_count_final: got %0d expected 0", count); end
      step();
      nVectors++;
      if (commitValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL inorder_commit_idle: got %b expected 0", commitValid); end
   endtask

   // Reset asserted between edges must clear state with no clock edge.
   task automatic test_reset_midrun();
      for (int i = 0; i < 5; i++) begin
         allocValid = 1'b1;
         allocRd    = 4'(i);
         step();
      end
      allocValid = 1'b0;
      nVectors++;
      if (count !== 4'd5) begin nMiscompares++; $display("[TB] FAIL midreset_count5: got %0d expected 5", count); end
      #2 rst_n = 1'b0;
      #1;
      nVectors++;
      if (count !== 4'd0) begin nMiscompares++; $display("[TB] FAIL midreset_count: got %0d expected 0", count); end
      nVectors++;
      if ({empty, allocTag} !== {1'b1, 3'd0}) begin nMiscompares++; $display("[TB] FAIL midreset_empty_tag: got empty=%b tag=%0d expected empty=1 tag=0", empty, allocTag); end
      @(negedge clk1);
      rst_n = 1'b1;
      step();
   endtask

   // Fill all eight entries, try a ninth, then free one slot.
   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         allocValid = 1'b1;
         allocRd    = 4'(i + 4);
         step();
      end
      nVectors++;
      if (count !== 4'd8) begin nMiscompares++; $display("[TB] FAIL full_count: got %0d expected 8", count); end
      nVectors++;
      if (allocReady !== 1'b0) begin nMiscompares++; $display("[TB] FAIL full_alloc_ready: got %b expected 0", allocReady); end
      nVectors++;
      if ({allocTag, empty} !== {3'd0, 1'b0}) begin nMiscompares++; $display("[TB] FAIL full_tag_empty: got tag=%0d empty=%b expected tag=0 empty=0", allocTag, empty); end
      allocRd = 4'hF;
      step();
      allocValid = 1'b0;
      nVectors++;
      if ({count, allocTag} !== {4'd8, 3'd0}) begin nMiscompares++; $display("[TB] FAIL full_ninth_alloc: got count=%0d tag=%0d expected count=8 tag=0", count, allocTag); end
      wbValid = 1'b1; wbTag = 3'd0; wbData = 8'hA0;
      step();
      wbValid = 1'b0;
      step();
      nVectors++;
      if ({commitValid, commitTag, commitRd, commitData} !== {1'b1, 3'd0, 4'd4, 8'hA0}) begin
         nMiscompares++; $display("[TB] FAIL full_commit0: got v=%b tag=%0d rd=%0d data=%h expected v=1 tag=0 rd=4 data=a0", commitValid, commitTag, commitRd, commitData);
      end
      nVectors++;
      if ({allocReady, count} !== {1'b1, 4'd7}) begin nMiscompares++; $display("[TB] FAIL full_ready_again: got ready=%b count=%0d expected ready=1 count=7", allocReady, count); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      nVectors++;
      if ({count, allocTag} !== {4'd0, 3'd0}) begin nMiscompares++; $display("[TB] FAIL full_cleanup: got count=%0d tag=%0d expected 0 0", count, allocTag); end
   endtask

   // Twelve alloc/writeback/commit sequences walk the tag through a wrap.
   task automatic test_wrap();
      for (int i = 0; i < 12; i++) begin
         nVectors++;
         if (allocTag !== 3'(i % 8)) begin nMiscompares++; $display("[TB] FAIL wrap_alloc_tag%0d: got %0d expected %0d", i, allocTag, i % 8); end
         allocValid = 1'b1;
         allocRd    = 4'(i);
         step();
         allocValid = 1'b0;
         wbValid    = 1'b1;
         wbTag      = 3'(i % 8);
         wbData     = 8'(i * 3 + 5);
         step();
         wbValid = 1'b0;
         step();
         nVectors++;
         if ({commitValid, commitTag, commitRd, commitData} !== {1'b1, 3'(i % 8), 4'(i), 8'(i * 3 + 5)}) begin
            nMiscompares++; $display("[TB] FAIL wrap_commit%0d: got v=%b tag=%0d rd=%0d data=%h expected v=1 tag=%0d rd=%0d data=%h", i, commitValid, commitTag, commitRd, commitData, i % 8, i, 8'(i * 3 + 5));
         end
         nVectors++;
         if (count > 4'd8) begin nMiscompares++; $display("[TB] FAIL wrap_count%0d: got %0d expected at most 8", i, count); end
      end
   endtask

   // With four entries in flight: head timing, alloc+commit, stray writeback.
   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) begin
         allocValid = 1'b1;
         allocRd    = 4'(i + 8);
         step();
      end
      allocValid = 1'b0;
      nVectors++;
      if ({count, allocTag} !== {4'd4, 3'd0}) begin nMiscompares++; $display("[TB] FAIL sim_setup: got count=%0d tag=%0d expected 4 0", count, allocTag); end
      wbValid = 1'b1; wbTag = 3'd4; wbData = 8'h44;
      step();
      wbValid = 1'b0;
      nVectors++;
      if (commitValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL sim_head_c1: got %b expected 0", commitValid); end
      allocValid = 1'b1; allocRd = 4'd12;
      step();
      allocValid = 1'b0;
      nVectors++;
      if ({commitValid, commitTag, commitRd, commitData} !== {1'b1, 3'd4, 4'd8, 8'h44}) begin
         nMiscompares++; $display("[TB] FAIL sim_head_c2: got v=%b tag=%0d rd=%0d data=%h expected v=1 tag=4 rd=8 data=44", commitValid, commitTag, commitRd, commitData);
      end
      nVectors++;
      if ({count, allocTag} !== {4'd4, 3'd1}) begin nMiscompares++; $display("[TB] FAIL sim_alloc_commit: got count=%0d tag=%0d expected 4 1", count, allocTag); end
      wbValid = 1'b1; wbTag = 3'd3; wbData = 8'hEE;
      step();
      wbValid = 1'b0;
      step();
      nVectors++;
      if ({commitValid, count, allocTag} !== {1'b0, 4'd4, 3'd1}) begin nMiscompares++; $display("[TB] FAIL sim_stray_wb: got v=%b count=%0d tag=%0d expected v=0 count=4 tag=1", commitValid, count, allocTag); end
   endtask

   // Flush with five entries, two done, then a stale writeback.
   task automatic test_flush();
      allocValid = 1'b1; allocRd = 4'd13;
      step();
      allocValid = 1'b0;
      wbValid = 1'b1; wbTag = 3'd6; wbData = 8'h66;
      step();
      wbTag = 3'd7; wbData = 8'h77;
      step();
      wbValid = 1'b0;
      nVectors++;
      if ({commitValid, count} !== {1'b0, 4'd5}) begin nMiscompares++; $display("[TB] FAIL flush_setup: got v=%b count=%0d expected v=0 count=5", commitValid, count); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      nVectors++;
      if ({count, commitValid, allocTag, empty} !== {4'd0, 1'b0, 3'd0, 1'b1}) begin
         nMiscompares++; $display("[TB] FAIL flush_clear: got count=%0d v=%b tag=%0d empty=%b expected 0 0 0 1", count, commitValid, allocTag, empty);
      end
      nVectors++;
      if ({commitTag, commitRd, commitData} !== {3'd4, 4'd8, 8'h44}) begin
         nMiscompares++; $display("[TB] FAIL flush_hold_payload: got tag=%0d rd=%0d data=%h expected tag=4 rd=8 data=44", commitTag, commitRd, commitData);
      end
      wbValid = 1'b1; wbTag = 3'd6; wbData = 8'h99;
      step();
      wbValid = 1'b0;
      step();
      nVectors++;
      if ({commitValid, count} !== {1'b0, 4'd0}) begin nMiscompares++; $display("[TB] FAIL flush_stale_wb: got v=%b count=%0d expected v=0 count=0", commitValid, count); end
   endtask

   // Scenario sequence and final summary.
   initial begin
      nVectors     = 0;
      nMiscompares = 0;
      idleInputs();
      rst_n = 1'b0;
      @(negedge clk1);
      test_reset();
      test_in_order();
      test_reset_midrun();
      test_full();
      test_wrap();
      test_simultaneous();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
# rob_commit

Eight-entry reorder buffer that receives out-of-order results from the execution unit and retires them to the register bank in program order. The issue stage allocates an entry and receives a 3-bit tag, which travels with the instruction to the execution unit. The execution unit writes its 8-bit result back by tag. This block is the consumer of exec's result writes: it reads completed entries at the head and produces one registered commit per cycle.

## Interface

Parameters:
- DEPTH, 8, number of entries; fixed at 8 because tags are 3 bits.
- DW, 8, result data width.
- RW, 4, destination register index width (16 registers).

Ports:
- clk1  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- alloc_valid  in  1  issue requests a new entry.
- alloc_rd  in  RW  destination register of the allocated instruction.
- alloc_ready  out  1  combinational; 1 when count < DEPTH.
- alloc_tag  out  3  combinational; equals tail; this is the tag given to the allocating instruction.
- wb_valid  in  1  exec result valid.
- wb_tag  in  3  ROB index of the result.
- wb_data  in  DW  result value.
- commit_valid  out  1  registered; 1-cycle pulse per retired entry.
- commit_tag  out  3  registered; tag of the retired entry.
- commit_rd  out  RW  registered; destination register.
- commit_data  out  DW  registered; value to write to the register bank.
- count  out  4  registered; occupied entries, 0..8.
- empty  out  1  combinational; (count == 0).

## Operation

- Per-entry state: busy, done, rd[RW], data[DW]. Head and tail pointers are 3 bits and wrap 7→0.
- Allocate: when alloc_valid && alloc_ready, entry[tail] is loaded with busy=1, done=0, rd=alloc_rd, and tail is incremented. alloc_valid while full is ignored, with no state change.
- Writeback: when wb_valid && busy[wb_tag], the block sets done=1 and data=wb_data. A writeback to a non-busy entry is ignored. A writeback to an entry that is already done overwrites its data. A writeback to the tag being allocated in the same cycle is ignored, because the entry is not yet busy.
- Commit: when busy[head] && done[head], the commit_* outputs are loaded from entry[head], commit_valid is set to 1, the entry is cleared (busy=0, done=0), and head is incremented. Otherwise commit_valid is 0. Commit decisions use the registered done bit, so a same-cycle writeback to the head does not commit in that cycle.
- There is no backpressure on commit. The register bank accepts every commit_valid.
- count is updated with +1 on allocate, −1 on commit, and unchanged when both occur or neither occurs.
- alloc_ready is computed from the current count. A full buffer blocks allocation even in a cycle that commits.
- flush has priority over alloc, wb and commit. It clears all busy and done bits, sets head=tail=count=0, and forces commit_valid=0 on the next edge. commit_tag, commit_rd and commit_data hold their previous values.
- Reset (rst_n=0, asynchronous) values: all busy/done bits=0, head=0, tail=0, count=0, commit_valid=0, commit_tag=0, commit_rd=0, commit_data=0. Consequently alloc_ready=1, alloc_tag=0 and empty=1. Reset asserted mid-operation discards all entries immediately.

## Timing

- Allocation is visible one edge later: busy is set and tail/alloc_tag advance.
- Writeback in cycle c to the current head gives commit_valid=1 in cycle c+2. The c edge sets done; the c+1 edge registers the commit.
- Entries that are already done behind the head commit back-to-back, one per cycle.
- Allocating and committing in the same cycle leaves count unchanged, and both pointers advance.
- With 8 entries allocated: count=8, alloc_ready=0 and head==tail. Full and empty are distinguished only by count.

## Test plan

- Reset → commit_valid=0, count=0, alloc_tag=0, alloc_ready=1, empty=1. Reset asserted mid-run with count=5 → count=0 immediately, with no clock edge required.
- Allocate rd=1,2,3 (tags 0,1,2); write back tag2=0x33, tag0=0x11, tag1=0x22 in consecutive cycles → commits in order: (tag0,rd1,0x11), then tag1 and tag2 in consecutive cycles; count returns to 0.
- Allocate 8 entries → count=8 and alloc_ready=0. A 9th alloc_valid causes no change: tail stays 0 and count stays 8. Write back and commit tag0 → alloc_ready returns to 1.
- Wrap-around: run 12 alloc/writeback/commit sequences → alloc_tag sequence is 0..7,0..3; commits stay in order and count never exceeds 8.
- Simultaneous events with count=4: alloc plus commit in one cycle → count stays 4. wb_valid to a non-busy tag → no commit and no state change. Head writeback in cycle c → commit_valid first high in cycle c+2.
- flush with 5 entries, 2 of them done → next cycle count=0, commit_valid=0, alloc_tag=0. A subsequent writeback to an old tag is ignored.
